helios_fifo_wrapper: RTL and testbench
======================================

// Module: helios_fifo_wrapper
// PURPOSE
// - Synchronous first-word-fall-through (FWFT) FIFO with valid/ready handshakes on both sides.
// - Used by the Helios single-FPGA decoder host link: one instance buffers 32-bit syndrome words into the decoder, one buffers result words out.
// - A single clock domain; no data transformation; strict in-order delivery.
// PARAMETERS
// - WIDTH  32   data word width in bits (>=1)
// - DEPTH  128  number of storage entries; power of two, >=2
// - Derived: AW = $clog2(DEPTH); pointers are AW+1 bits wide (extra wrap bit)
// PORTS
// - clk           in   1      clock, all state updates on posedge
// - reset         in   1      reset, synchronous, active-high
// - input_data    in   WIDTH  write-side word
// - input_valid   in   1      write-side word offered
// - input_ready   out  1      FIFO can accept a word this cycle
// - output_data   out  WIDTH  head-of-queue word (FWFT)
// - output_valid  out  1      head word present
// - output_ready  in   1      consumer takes head word this cycle
// - level         out  AW+1   occupancy, 0..DEPTH (only with HELIOS_FIFO_LEVEL_EN)
// BEHAVIOUR
// - Storage: DEPTH x WIDTH array; wr_ptr/rd_ptr AW+1 bits; index = ptr[AW-1:0]; both wrap modulo 2*DEPTH.
// - empty = (wr_ptr == rd_ptr); full = (ptr[AW-1:0] equal) && (ptr[AW] differ).
// - push = input_valid && input_ready; pop = output_valid && output_ready.
// - input_ready = !full && !reset (combinational); input_ready does NOT depend on a same-cycle pop.
// - output_valid = !empty (combinational from registered pointers); output_data = mem[rd_ptr] when !empty, else all zeros.
// - Push: mem[wr_ptr] <= input_data, wr_ptr <= wr_ptr+1 at posedge.
// - Pop: rd_ptr <= rd_ptr+1 at posedge.
// - Latency: a word pushed into an empty FIFO at edge N is visible (output_valid=1) in the cycle after edge N; no bypass path.
// - Simultaneous push+pop: both take effect; occupancy unchanged; legal at any non-empty, non-full level.
// - Full: push blocked (input_ready=0), so input_valid with full drops nothing; a pop that cycle frees one slot for the next cycle.
// - Empty: output_valid=0; output_ready is ignored; pointers are not moved.
// - Ordering: words leave in exactly the order accepted; no loss, no duplication.
// - Reset (incl. mid-operation): wr_ptr=rd_ptr=0 next edge; output_valid=0, output_data=0, input_ready=0 while reset is high, 1 on the first cycle after; level=0; stored contents discarded (array not cleared).
// - output_data and output_valid stay stable while output_valid=1 and output_ready=0.
// CONFIGURATION
// - Macro HELIOS_FIFO_LEVEL_EN:
//   - defined: port `level` exists; a registered counter is +1 on push only, -1 on pop only, unchanged on both or neither; reset 0; equals wr_ptr-rd_ptr.
//   - undefined: no `level` port, no counter logic; all other behaviour identical.
// TESTING
// - Reset then idle -> output_valid=0, output_data=0, input_ready=1 one cycle after reset drops; level=0.
// - Push 0x11,0x22,0x33 back-to-back, output_ready=0 -> output_valid=1 one cycle after first push, output_data=0x11 held; level=3.
// - Then output_ready=1 for 3 cycles -> read 0x11,0x22,0x33 in order, then output_valid=0.
// - Push 128 words i=0..127 with no pop -> input_ready=0 after 128th, 129th word 0xDEAD held off; drain -> 0..127 exact, 0xDEAD enters only after first pop.
// - At level=5, push+pop same cycle for 50 cycles with random data -> level stays 5, output sequence matches a reference queue.
// - Assert reset with 10 words stored -> next cycle output_valid=0, level=0; push 0xAB -> first word out is 0xAB.

Source files
------------

// File: rtl/helios_fifo_wrapper.sv
// helios_fifo_wrapper: single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Define HELIOS_FIFO_LEVEL_EN to add the registered occupancy output `level`.
module helios_fifo_wrapper #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] input_data,
    input  logic             input_valid,
    output logic             input_ready,
    output logic [WIDTH-1:0] output_data,
    output logic             output_valid,
    input  logic             output_ready
`ifdef HELIOS_FIFO_LEVEL_EN
    ,
    output logic [AW:0]      level
`endif
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic empty, full, push, pop;

    // Pointers carry an extra wrap bit so equal indices can be told apart as empty or full.
    assign empty        = wr_ptr_q == rd_ptr_q;
    assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign input_ready  = !full && !reset;
    assign output_valid = !empty && !reset;
    assign output_data  = output_valid ? mem[rd_ptr_q[AW-1:0]] : '0;
    assign push         = input_valid && input_ready;
    assign pop          = output_valid && output_ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= input_data;
    end

`ifdef HELIOS_FIFO_LEVEL_EN
    logic [AW:0] level_q, level_d;

    always_comb begin
        level_d = (push && !pop) ? level_q + 1'b1 : (pop && !push) ? level_q - 1'b1 : level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) level_q <= '0;
        else level_q <= level_d;
    end

    assign level = level_q;
`endif
endmodule

// File: tb/tb_helios_fifo_wrapper.sv
// tb_helios_fifo_wrapper: randomized and directed checks of helios_fifo_wrapper against a queue model.
// Level checks are active when HELIOS_FIFO_LEVEL_EN is defined.
module tb_helios_fifo_wrapper;
    localparam int WIDTH = 32;
    localparam int DEPTH = 128;
    localparam int AW = $clog2(DEPTH);

    logic             clk = 0;
    logic             reset = 1;
    logic [WIDTH-1:0] input_data = '0;
    logic             input_valid = 0;
    logic             input_ready;
    logic [WIDTH-1:0] output_data;
    logic             output_valid;
    logic             output_ready = 0;
`ifdef HELIOS_FIFO_LEVEL_EN
    logic [AW:0]      level;
`endif

    int checks = 0;
    int failures = 0;
    logic [WIDTH-1:0] q[$];

    helios_fifo_wrapper #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .input_data(input_data),
        .input_valid(input_valid),
        .input_ready(input_ready),
        .output_data(output_data),
        .output_valid(output_valid),
        .output_ready(output_ready)
`ifdef HELIOS_FIFO_LEVEL_EN
        ,
        .level(level)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; the queue model applies the accept/take rules to the pre-edge inputs.
    task automatic tick();
        bit push, pop;
        logic [WIDTH-1:0] d;
        push = input_valid && !reset && q.size() < DEPTH;
        pop  = output_ready && !reset && q.size() > 0;
        d    = input_data;
        @(posedge clk);
        #1;
        if (reset) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        input_valid = 1;
        input_data = 32'h5555_AAAA;
        output_ready = 1;
        repeat (3) tick();
        checks++;
        if (input_ready !== 1'b0 || output_valid !== 1'b0 || output_data !== '0) begin
            failures++;
            $display("FAIL reset_high: ready=%b valid=%b data=%h want 0 0 0", input_ready, output_valid, output_data);
        end
        input_valid = 0;
        output_ready = 0;
        reset = 0;
        tick();
        checks++;
        if (input_ready !== 1'b1 || output_valid !== 1'b0 || output_data !== '0) begin
            failures++;
            $display("FAIL reset_idle: ready=%b valid=%b data=%h want 1 0 0", input_ready, output_valid, output_data);
        end
`ifdef HELIOS_FIFO_LEVEL_EN
        checks++;
        if (level !== 0) begin
            failures++;
            $display("FAIL reset_level: got %0d want 0", level);
        end
`endif
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] exp[3] = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) begin
            input_valid = 1;
            input_data = exp[i];
            tick();
            checks++;
            if (output_valid !== 1'b1 || output_data !== 32'h11) begin
                failures++;
                $display("FAIL basic_push%0d: valid=%b data=%h want 1 00000011", i, output_valid, output_data);
            end
        end
        input_valid = 0;
        repeat (2) begin
            tick();
            checks++;
            if (output_valid !== 1'b1 || output_data !== 32'h11) begin
                failures++;
                $display("FAIL basic_hold: valid=%b data=%h want 1 00000011", output_valid, output_data);
            end
        end
`ifdef HELIOS_FIFO_LEVEL_EN
        checks++;
        if (level !== 3) begin
            failures++;
            $display("FAIL basic_level: got %0d want 3", level);
        end
`endif
        output_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (output_valid !== 1'b1 || output_data !== exp[i]) begin
                failures++;
                $display("FAIL basic_read%0d: valid=%b data=%h want 1 %h", i, output_valid, output_data, exp[i]);
            end
            tick();
        end
        output_ready = 0;
        checks++;
        if (output_valid !== 1'b0 || output_data !== '0) begin
            failures++;
            $display("FAIL basic_empty: valid=%b data=%h want 0 0", output_valid, output_data);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            input_valid = 1;
            input_data = WIDTH'(i);
            tick();
        end
        input_data = 32'hDEAD;
        repeat (2) begin
            checks++;
            if (input_ready !== 1'b0 || output_data !== '0) begin
                failures++;
                $display("FAIL full_block: ready=%b head=%h want 0 0", input_ready, output_data);
            end
`ifdef HELIOS_FIFO_LEVEL_EN
            checks++;
            if (level !== DEPTH) begin
                failures++;
                $display("FAIL full_level: got %0d want %0d", level, DEPTH);
            end
`endif
            tick();
        end
        output_ready = 1;
        for (int k = 0; k <= DEPTH; k++) begin
            logic [WIDTH-1:0] want;
            want = (k < DEPTH) ? WIDTH'(k) : 32'hDEAD;
            checks++;
            if (output_valid !== 1'b1 || output_data !== want || input_ready !== (k != 0)) begin
                failures++;
                $display("FAIL full_drain%0d: valid=%b data=%h ready=%b want 1 %h %b", k, output_valid, output_data, input_ready, want, k != 0);
            end
            tick();
            if (k == 1) input_valid = 0;
        end
        output_ready = 0;
        checks++;
        if (output_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_empty: valid=%b want 0", output_valid);
        end
    endtask

    task automatic test_steady();
        output_ready = 0;
        for (int i = 0; i < 5; i++) begin
            input_valid = 1;
            input_data = $urandom;
            tick();
        end
        output_ready = 1;
        for (int i = 0; i < 50; i++) begin
            input_data = $urandom;
            checks++;
            if (output_valid !== 1'b1 || output_data !== q[0] || input_ready !== 1'b1) begin
                failures++;
                $display("FAIL steady%0d: valid=%b data=%h ready=%b want 1 %h 1", i, output_valid, output_data, input_ready, q[0]);
            end
`ifdef HELIOS_FIFO_LEVEL_EN
            checks++;
            if (level !== 5) begin
                failures++;
                $display("FAIL steady_level%0d: got %0d want 5", i, level);
            end
`endif
            tick();
        end
        input_valid = 0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (output_data !== q[0]) begin
                failures++;
                $display("FAIL steady_drain%0d: got %h want %h", i, output_data, q[0]);
            end
            tick();
        end
        output_ready = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            input_valid = ($urandom_range(3) != 0);
            output_ready = ($urandom_range(2) != 0);
            input_data = $urandom;
            tick();
            checks++;
            if (output_valid !== (q.size() > 0) || input_ready !== (q.size() < DEPTH) ||
                output_data !== (q.size() > 0 ? q[0] : '0)) begin
                failures++;
                $display("FAIL random%0d: valid=%b ready=%b data=%h want %b %b %h", i, output_valid, input_ready,
                         output_data, q.size() > 0, q.size() < DEPTH, q.size() > 0 ? q[0] : '0);
            end
`ifdef HELIOS_FIFO_LEVEL_EN
            checks++;
            if (level !== q.size()) begin
                failures++;
                $display("FAIL random_level%0d: got %0d want %0d", i, level, q.size());
            end
`endif
        end
        input_valid = 0;
        output_ready = 1;
        repeat (DEPTH + 2) tick();
        output_ready = 0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            input_valid = 1;
            input_data = $urandom;
            tick();
        end
        input_valid = 0;
        reset = 1;
        tick();
        checks++;
        if (output_valid !== 1'b0 || input_ready !== 1'b0 || output_data !== '0) begin
            failures++;
            $display("FAIL midreset: valid=%b ready=%b data=%h want 0 0 0", output_valid, input_ready, output_data);
        end
        reset = 0;
        tick();
`ifdef HELIOS_FIFO_LEVEL_EN
        checks++;
        if (level !== 0) begin
            failures++;
            $display("FAIL midreset_level: got %0d want 0", level);
        end
`endif
        checks++;
        if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_after: valid=%b ready=%b want 0 1", output_valid, input_ready);
        end
        input_valid = 1;
        input_data = 32'hAB;
        tick();
        input_valid = 0;
        checks++;
        if (output_valid !== 1'b1 || output_data !== 32'hAB) begin
            failures++;
            $display("FAIL midreset_first: valid=%b data=%h want 1 000000ab", output_valid, output_data);
        end
        output_ready = 1;
        tick();
        output_ready = 0;
        checks++;
        if (output_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_drain: valid=%b want 0", output_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_steady();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
